// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - wait-state data memory responder (IDLE/WAIT/RESP); `DMEM_WAIT_EN builds the WAIT state and counter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dmem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [`ADDR_WIDTH-1:0] addr_i,
  input  logic [`DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]             be_i,
  output logic [`DATA_WIDTH-1:0] rdata_o,
  output logic                   ack_o,
  output logic                   err_o,
  output logic                   stallreq_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                  state;
  logic                    lat_we;
  logic                    lat_err;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [`DATA_WIDTH-1:0]  lat_wdata;
  logic [3:0]              lat_be;
  logic [`DATA_WIDTH-1:0]  mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    req_err;
  logic                    enter_resp;
  logic                    src_we;
  logic                    src_err;
  logic [DEPTH_LOG2-1:0]   src_idx;
  logic                    unused_bits;

  assign req_idx = addr_i[DEPTH_LOG2+1:2];
  assign req_err = |(addr_i >> (DEPTH_LOG2 + 2));

`ifdef DMEM_WAIT_EN
  localparam bit DIRECT = (WAIT_CYCLES == 0);
  logic [3:0] cnt;
  assign unused_bits = ^addr_i[1:0];
`else
  localparam bit DIRECT = 1'b1;
  assign unused_bits = ^{addr_i[1:0], 4'(WAIT_CYCLES)};
`endif

  assign stallreq_o = rst_i && ((state == IDLE && req_i) || state == WAIT);

  // Source of the access that enters RESP this cycle: live inputs when IDLE skips WAIT, latched otherwise
  always_comb begin
    enter_resp = 1'b0;
    src_we     = we_i;
    src_err    = req_err;
    src_idx    = req_idx;
    if (state == IDLE) begin
      enter_resp = req_i && DIRECT;
    end
`ifdef DMEM_WAIT_EN
    else if (state == WAIT) begin
      enter_resp = (cnt == 4'd0);
      src_we     = lat_we;
      src_err    = lat_err;
      src_idx    = lat_idx;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
`ifdef DMEM_WAIT_EN
      cnt       <= 4'd0;
`endif
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (enter_resp) begin
        ack_o <= 1'b1;
        err_o <= src_err;
        if (!src_we) rdata_o <= src_err ? '0 : mem[src_idx];
      end
      case (state)
        IDLE: if (req_i) begin
          lat_we    <= we_i;
          lat_err   <= req_err;
          lat_idx   <= req_idx;
          lat_wdata <= wdata_i;
          lat_be    <= be_i;
`ifdef DMEM_WAIT_EN
          cnt       <= 4'(WAIT_CYCLES - 1);
`endif
          state     <= DIRECT ? RESP : WAIT;
        end
`ifdef DMEM_WAIT_EN
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never reset; a reset in RESP drops state to IDLE so the write is lost
  always_ff @(posedge clk_i) begin
    if (state == RESP && lat_we && !lat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - scoreboard bench for dmem_resp: latency, byte enables, range errors, reset abort
module tb_dmem_resp;

`ifdef DMEM_WAIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] model [int];
  logic [31:0] last_rdata = '0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          first_ack = 0;

  dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata), .ack_o(ack), .err_o(err),
    .stallreq_o(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit bb, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    sb_t e;
    int  i;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    e.err  = (a >> 12) != 0;
    e.rd   = !w;
    e.data = '0;
    i = int'(a[11:2]);
    if (w && !e.err) begin
      logic [31:0] v;
      v = model.exists(i) ? model[i] : 32'h0;
      for (int k = 0; k < 4; k++) if (b[k]) v[8*k +: 8] = d[8*k +: 8];
      model[i] = v;
    end
    if (!w && !e.err) e.data = model[i];
    sbq.push_back(e);
    if (bb) @(negedge clk);
    #1;
    check("stall_c0", {31'b0, stall}, 32'd1);
    check("ack_c0", {31'b0, ack}, 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk); #1;
      check("stall_wait", {31'b0, stall}, 32'd1);
      check("ack_wait", {31'b0, ack}, 32'd0);
    end
    @(negedge clk); #1;
    check("ack_resp", {31'b0, ack}, 32'd1);
    check("stall_resp", {31'b0, stall}, 32'd0);
    e = sbq.pop_front();
    check("err", {31'b0, err}, {31'b0, e.err});
    if (e.rd) begin
      check("rdata", rdata, e.data);
      last_rdata = e.data;
    end else begin
      check("rdata_hold_wr", rdata, last_rdata);
    end
    ack_cyc = cyc;
  endtask

  task automatic idle_cycle();
    req = 1'b0;
    @(negedge clk); #1;
    check("ack_pulse_end", {31'b0, ack}, 32'd0);
    check("stall_idle", {31'b0, stall}, 32'd0);
    check("rdata_hold", rdata, last_rdata);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); idle_cycle();
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF);        idle_cycle();
    issue(0, 1'b1, 32'h10, 32'h11223344, 4'b0101); idle_cycle();
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF);        idle_cycle();
    check("byte_merge", last_rdata, 32'hDE22BE44);

    issue(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);  idle_cycle();
    issue(0, 1'b0, 32'h1000, 32'h0, 4'hF);      idle_cycle();
    issue(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF); idle_cycle();
    issue(0, 1'b0, 32'h3, 32'h0, 4'hF);         idle_cycle();
    issue(0, 1'b1, 32'h10, 32'h0, 4'h0);        idle_cycle();
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF);        idle_cycle();
    issue(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF); idle_cycle();
    issue(0, 1'b0, 32'hFFF, 32'h0, 4'hF);       idle_cycle();
    issue(0, 1'b0, 32'h80000000, 32'h0, 4'hF);  idle_cycle();

    // Request held high across RESP: next access starts in the following IDLE cycle
    issue(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    first_ack = ack_cyc;
    issue(1, 1'b0, 32'h20, 32'h0, 4'hF);
    check("bb_spacing", ack_cyc - first_ack, LAT + 2);
    idle_cycle();

    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h12345678; be = 4'hF;
    @(negedge clk); #1;
    rst = 1'b0; #1;
    check("abort_ack", {31'b0, ack}, 32'd0);
    check("abort_err", {31'b0, err}, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    last_rdata = '0;
    req = 1'b0;
    @(negedge clk); #1;
    check("abort_no_ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF); idle_cycle();
    check("abort_word_kept", last_rdata, 32'hDE22BE44);

    check("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words in the internal data array.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait cycles inserted per access (range 0..15).
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  1  access request from the mem stage; held stable while stallreq_o=1.
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  input  `ADDR_WIDTH  byte address.
REQ-008 wdata_i  input  `DATA_WIDTH  write data.
REQ-009 be_i  input  4  byte enables; bit n selects wdata_i[8n+7:8n].
REQ-010 rdata_o  output  `DATA_WIDTH  registered read data.
REQ-011 ack_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  out-of-range flag, valid only when ack_o=1.
REQ-013 stallreq_o  output  1  stall request to pipe_ctrl.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 IDLE with req_i=1 SHALL latch we_i, addr_i, wdata_i and be_i, and load a 4-bit counter with WAIT_CYCLES-1; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 0.
REQ-017 RESP SHALL assert ack_o for exactly one cycle and unconditionally return to IDLE.
REQ-018 stallreq_o SHALL be combinational: 1 in IDLE when req_i=1, 1 throughout WAIT, and 0 in RESP.
REQ-019 Latency: for a request first seen in IDLE at cycle 0, ack_o SHALL be high in cycle WAIT_CYCLES+1, and stallreq_o SHALL be high in cycles 0..WAIT_CYCLES.
REQ-020 Word index SHALL be addr_i[DEPTH_LOG2+1:2]; addr_i[1:0] is ignored.
REQ-021 A request SHALL be out of range when any addr_i bit above DEPTH_LOG2+1 is nonzero.
REQ-022 For an in-range write, the enabled bytes SHALL be written on the clock edge that ends RESP; disabled bytes SHALL be unchanged.
REQ-023 For an in-range read, rdata_o SHALL be loaded on the edge entering RESP and SHALL hold until the next read completes.
REQ-024 For an out-of-range access, err_o=1 with ack_o, the write is suppressed, and a read returns rdata_o=0.
REQ-025 req_i SHALL be ignored in WAIT and RESP (the same held request); the next access is accepted only in IDLE.
REQ-026 be_i=4'b0000 on a write SHALL complete with ack_o and leave memory unchanged.
REQ-027 A read of a word issued immediately after a write to the same word SHALL return the newly written data.

Reset
REQ-028 rst_i=0 SHALL asynchronously force state IDLE, counter 0, ack_o=0, err_o=0, stallreq_o=0 and rdata_o=0.
REQ-029 Reset SHALL NOT clear the data array.
REQ-030 Reset during WAIT or RESP SHALL abort the access with no write performed and no ack_o.

Configuration
REQ-031 Macro DMEM_WAIT_EN.
- Defined: the WAIT state and counter are built and behave per REQ-015/016.
- Undefined: the WAIT state and counter are omitted, WAIT_CYCLES is ignored, IDLE goes directly to RESP, and every access stalls exactly one cycle.

Verification
REQ-032 WAIT_CYCLES=2, write addr 0x10, data 0xDEADBEEF, be 4'hF -> stallreq_o high cycles 0-2, ack_o at cycle 3, err_o=0.
REQ-033 Read addr 0x10 after REQ-032 -> rdata_o=0xDEADBEEF at ack_o, held after ack_o.
REQ-034 Write addr 0x10, data 0x11223344, be 4'b0101 -> subsequent read returns 0xDE22BE44.
REQ-035 DEPTH_LOG2=10, read addr 0x00001000 -> err_o=1 with ack_o, rdata_o=0; write to the same address leaves word 0 unchanged.
REQ-036 rst_i pulsed low during WAIT of a write -> outputs 0 immediately, no ack_o, target word unchanged.
REQ-037 DMEM_WAIT_EN undefined (or WAIT_CYCLES=0) -> stallreq_o high one cycle, ack_o in cycle 1; back-to-back requests are accepted every 2 cycles.
